btn_event_gen: RTL and testbench

- Consumes the three debounced button levels from the button debouncer and converts each into one-cycle event pulses: press, short-press (on release), long-press and auto-repeat.
- Sits between the debouncer and the control/UI FSMs, which act on pulses and never on levels.
- Each button has its own independent FSM and counter. Parameters are in clock cycles; defaults assume a 100 MHz clk.

---
 rtl/btn_event_gen_if.sv | 20 ++
 rtl/btn_event_gen.sv | 140 ++++++++++++++
 tb/tb_btn_event_gen.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/btn_event_gen_if.sv
// Button-event bundle: debounced button levels in, per-button event pulses and held levels out.
// The master side drives the button levels; the slave side (the event generator) returns the events.
interface btn_event_gen_if;
   logic [2:0] btn;
   logic [2:0] press_pulse;
   logic [2:0] short_pulse;
   logic [2:0] long_pulse;
   logic [2:0] repeat_pulse;
   logic [2:0] held;

   modport master (
      output btn,
      input  press_pulse, short_pulse, long_pulse, repeat_pulse, held
   );

   modport slave (
      input  btn,
      output press_pulse, short_pulse, long_pulse, repeat_pulse, held
   );
endinterface

// File: rtl/btn_event_gen.sv
// Converts three debounced button levels into registered one-cycle press/short/long/repeat
// pulses plus a held level, using one independent FSM and 27-bit counter per button.
module btn_event_gen #(
   parameter logic [26:0] LONG_LIMIT   = 27'd100_000_000,
   parameter logic [26:0] REPEAT_LIMIT = 27'd20_000_000,
   parameter logic        REPEAT_EN    = 1'b1
) (
   input logic           clk,
   input logic           reset,
   btn_event_gen_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2
   } state_t;

   localparam logic [26:0] LONG_LAST   = LONG_LIMIT - 27'd1;
   localparam logic [26:0] REPEAT_LAST = REPEAT_LIMIT - 27'd1;

   state_t      state_r     [3];
   state_t      state_nxt_s [3];
   logic [26:0] count_r     [3];
   logic [26:0] count_nxt_s [3];

   logic [2:0] press_r,  short_r,  long_r,  repeat_r,  held_r;
   logic [2:0] press_s,  short_s,  long_s,  repeat_s,  held_s;

   // State, counter and output registers for all three buttons.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 3; i++) begin
            state_r[i] <= ST_IDLE;
            count_r[i] <= 27'd0;
         end
         press_r  <= 3'd0;
         short_r  <= 3'd0;
         long_r   <= 3'd0;
         repeat_r <= 3'd0;
         held_r   <= 3'd0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            state_r[i] <= state_nxt_s[i];
            count_r[i] <= count_nxt_s[i];
         end
         press_r  <= press_s;
         short_r  <= short_s;
         long_r   <= long_s;
         repeat_r <= repeat_s;
         held_r   <= held_s;
      end
   end

   // Next-state and counter logic; a release always takes priority over a count match.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         state_nxt_s[i] = state_r[i];
         count_nxt_s[i] = count_r[i];
         case (state_r[i])
            ST_IDLE: begin
               if (bus.btn[i]) begin
                  state_nxt_s[i] = ST_HOLD;
                  count_nxt_s[i] = 27'd0;
               end else begin
                  state_nxt_s[i] = ST_IDLE;
               end
            end
            ST_HOLD: begin
               if (!bus.btn[i]) begin
                  state_nxt_s[i] = ST_IDLE;
                  count_nxt_s[i] = 27'd0;
               end else if (count_r[i] == LONG_LAST) begin
                  state_nxt_s[i] = ST_REPEAT;
                  count_nxt_s[i] = 27'd0;
               end else begin
                  count_nxt_s[i] = count_r[i] + 27'd1;
               end
            end
            ST_REPEAT: begin
               if (!bus.btn[i]) begin
                  state_nxt_s[i] = ST_IDLE;
                  count_nxt_s[i] = 27'd0;
               end else if (count_r[i] == REPEAT_LAST) begin
                  count_nxt_s[i] = 27'd0;
               end else begin
                  count_nxt_s[i] = count_r[i] + 27'd1;
               end
            end
            default: begin
               state_nxt_s[i] = ST_IDLE;
               count_nxt_s[i] = 27'd0;
            end
         endcase
      end
   end

   // Pulse decode; each branch raises at most one pulse so pulses stay mutually exclusive.
   always_comb begin
      press_s  = 3'd0;
      short_s  = 3'd0;
      long_s   = 3'd0;
      repeat_s = 3'd0;
      held_s   = 3'd0;
      for (int i = 0; i < 3; i++) begin
         held_s[i] = (state_nxt_s[i] != ST_IDLE);
         case (state_r[i])
            ST_IDLE: begin
               press_s[i] = bus.btn[i];
            end
            ST_HOLD: begin
               if (!bus.btn[i]) begin
                  short_s[i] = 1'b1;
               end else if (count_r[i] == LONG_LAST) begin
                  long_s[i] = 1'b1;
               end else begin
                  long_s[i] = 1'b0;
               end
            end
            ST_REPEAT: begin
               if (bus.btn[i] && (count_r[i] == REPEAT_LAST)) begin
                  repeat_s[i] = REPEAT_EN;
               end else begin
                  repeat_s[i] = 1'b0;
               end
            end
            default: begin
               held_s[i] = 1'b0;
            end
         endcase
      end
   end

   assign bus.press_pulse  = press_r;
   assign bus.short_pulse  = short_r;
   assign bus.long_pulse   = long_r;
   assign bus.repeat_pulse = repeat_r;
   assign bus.held         = held_r;

endmodule

// File: tb/tb_btn_event_gen.sv
// Directed bench for btn_event_gen: one instance with auto-repeat, one with repeat disabled,
// outputs compared cycle by cycle against hand-computed vectors.
module tb_btn_event_gen;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   btn_event_gen_if bus ();
   btn_event_gen_if bus_nr ();

   btn_event_gen #(
      .LONG_LIMIT  (27'd10),
      .REPEAT_LIMIT(27'd4),
      .REPEAT_EN   (1'b1)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   btn_event_gen #(
      .LONG_LIMIT  (27'd10),
      .REPEAT_LIMIT(27'd4),
      .REPEAT_EN   (1'b0)
   ) dut_nr (
      .clk  (clk),
      .reset(reset),
      .bus  (bus_nr)
   );

   // Packs expected {press, short, long, repeat, held}.
   function automatic logic [14:0] v(input logic [2:0] p, input logic [2:0] s,
                                     input logic [2:0] l, input logic [2:0] r,
                                     input logic [2:0] h);
      return {p, s, l, r, h};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input bit nr, input int k, input logic [14:0] exp);
      logic [14:0] obs;
      if (nr) begin
         obs = {bus_nr.press_pulse, bus_nr.short_pulse, bus_nr.long_pulse,
                bus_nr.repeat_pulse, bus_nr.held};
      end else begin
         obs = {bus.press_pulse, bus.short_pulse, bus.long_pulse, bus.repeat_pulse, bus.held};
      end
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s step %0d observed p/s/l/r/h=%b expected=%b", tag, k, obs, exp);
      end
   endtask

   initial begin
      bus.btn    = 3'b000;
      bus_nr.btn = 3'b000;
      #12;
      expect_out("reset_state", 1'b0, 0, 15'd0);
      reset = 1'b1;
      tick();
      expect_out("idle_after_reset", 1'b0, 0, 15'd0);

      // Scenario 1: short press on L for 5 cycles.
      bus.btn = 3'b001;
      for (int k = 0; k < 5; k++) begin
         tick();
         expect_out("s1_hold", 1'b0, k, v((k == 0) ? 3'b001 : 3'b000, 3'b000, 3'b000, 3'b000, 3'b001));
      end
      bus.btn = 3'b000;
      tick();
      expect_out("s1_short", 1'b0, 5, v(3'b000, 3'b001, 3'b000, 3'b000, 3'b000));
      tick();
      expect_out("s1_quiet", 1'b0, 6, 15'd0);

      // Scenario 2: long hold with repeat on C for 20 cycles.
      bus.btn = 3'b010;
      for (int k = 0; k < 20; k++) begin
         tick();
         expect_out("s2_hold", 1'b0, k, v((k == 0) ? 3'b010 : 3'b000, 3'b000,
                                          (k == 10) ? 3'b010 : 3'b000,
                                          ((k == 14) || (k == 18)) ? 3'b010 : 3'b000, 3'b010));
      end
      bus.btn = 3'b000;
      tick();
      expect_out("s2_release", 1'b0, 20, 15'd0);

      // Scenario 3: release exactly on the long threshold edge on R.
      bus.btn = 3'b100;
      for (int k = 0; k < 10; k++) begin
         tick();
         expect_out("s3_hold", 1'b0, k, v((k == 0) ? 3'b100 : 3'b000, 3'b000, 3'b000, 3'b000, 3'b100));
      end
      bus.btn = 3'b000;
      tick();
      expect_out("s3_short", 1'b0, 10, v(3'b000, 3'b100, 3'b000, 3'b000, 3'b000));
      tick();
      expect_out("s3_no_long", 1'b0, 11, 15'd0);

      // Scenario 4: overlapping L and C presses released together.
      bus.btn = 3'b001;
      for (int k = 0; k < 8; k++) begin
         if (k == 3) bus.btn = 3'b011;
         tick();
         expect_out("s4_hold", 1'b0, k, v((k == 0) ? 3'b001 : ((k == 3) ? 3'b010 : 3'b000),
                                          3'b000, 3'b000, 3'b000, (k < 3) ? 3'b001 : 3'b011));
      end
      bus.btn = 3'b000;
      tick();
      expect_out("s4_short", 1'b0, 8, v(3'b000, 3'b011, 3'b000, 3'b000, 3'b000));

      // Scenario 5: reset in the middle of a hold, button still down at release.
      bus.btn = 3'b001;
      for (int k = 0; k < 12; k++) begin
         tick();
         expect_out("s5_hold", 1'b0, k, v((k == 0) ? 3'b001 : 3'b000, 3'b000,
                                          (k == 10) ? 3'b001 : 3'b000, 3'b000, 3'b001));
      end
      #2;
      reset = 1'b0;
      #1;
      expect_out("s5_async_clear", 1'b0, 12, 15'd0);
      #1;
      reset = 1'b1;
      for (int k = 0; k < 11; k++) begin
         tick();
         expect_out("s5_repress", 1'b0, k, v((k == 0) ? 3'b001 : 3'b000, 3'b000,
                                             (k == 10) ? 3'b001 : 3'b000, 3'b000, 3'b001));
      end
      bus.btn = 3'b000;
      tick();
      expect_out("s5_release_repeat", 1'b0, 11, 15'd0);

      // Scenario 6: repeat disabled, hold L for 30 cycles.
      bus_nr.btn = 3'b001;
      for (int k = 0; k < 30; k++) begin
         tick();
         expect_out("s6_hold", 1'b1, k, v((k == 0) ? 3'b001 : 3'b000, 3'b000,
                                          (k == 10) ? 3'b001 : 3'b000, 3'b000, 3'b001));
      end
      bus_nr.btn = 3'b000;
      tick();
      expect_out("s6_release", 1'b1, 30, 15'd0);
      expect_out("s6_main_quiet", 1'b0, 30, 15'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
